// File: rtl/alu16_seq_ctrl.sv
// Request/response sequencer for a 16-bit ALU: single-pass ops go through one
// ALU evaluation, and multiply runs as 16 shift-add steps on the ALU add path.
module alu16_seq_ctrl #(
  parameter logic [2:0] ADD_OP    = 3'b000,
  parameter logic [2:0] MUL_OP    = 3'b111,
  parameter int         MUL_ITERS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [2:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  localparam logic [3:0] LAST_ITER = 4'(MUL_ITERS - 1);

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rsp_result_q, rsp_result_d;

  logic [15:0] sum;
  logic        carry;
  logic [31:0] shifted;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_result = rsp_result_q;

  // One shift-add step: the carry out of hi+M is recovered from the 16-bit
  // sum wrapping below M, so only the low half of the ALU result is needed.
  assign sum     = alu_result[15:0];
  assign carry   = (sum < a_q);
  assign shifted = lo_q[0] ? {carry, sum, lo_q[15:1]} : {1'b0, hi_q, lo_q[15:1]};

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    alu_a        = 16'h0000;
    alu_b        = 16'h0000;
    alu_op       = ADD_OP;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          a_d  = req_a;
          b_d  = req_b;
          op_d = req_op;
          if (req_op == MUL_OP) begin
            hi_d    = 16'h0000;
            lo_d    = req_b;
            cnt_d   = 4'd0;
            state_d = MUL;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        alu_a        = a_q;
        alu_b        = b_q;
        alu_op       = op_q;
        rsp_result_d = alu_result;
        state_d      = RESP;
      end
      MUL: begin
        alu_a  = hi_q;
        alu_b  = a_q;
        alu_op = ADD_OP;
        hi_d   = shifted[31:16];
        lo_d   = shifted[15:0];
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          rsp_result_d = shifted;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      op_q         <= 3'b000;
      hi_q         <= 16'h0000;
      lo_q         <= 16'h0000;
      cnt_q        <= 4'd0;
      rsp_result_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
    end
  end

endmodule

// File: tb/tb_alu16_seq_ctrl.sv
// Directed bench for alu16_seq_ctrl; the bench also plays the combinational ALU.
module tb_alu16_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Reference ALU: 16-bit result zero-extended; slt is signed. The mult path
  // returns a marker value so any use of it corrupts the product.
  function automatic logic [31:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
    logic [15:0] r;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      3'b011: r = a & b;
      3'b100: r = a | b;
      3'b101: r = a ^ b;
      3'b110: r = ~(a | b);
      default: return 32'hDEAD_BEEF;
    endcase
    return {16'h0000, r};
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_op);

  alu16_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL reset_rsp_valid got %h want 0", rsp_valid); end
    n_vec++; if (rsp_result !== 32'h0) begin n_miss++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %h want 0", busy); end
    n_vec++; if ({alu_a, alu_b, alu_op} !== 35'h0) begin n_miss++; $display("FAIL reset_alu got a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op); end
    n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL reset_req_ready_in_reset got %h want 0", req_ready); end
    reset = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL reset_req_ready_after got %h want 1", req_ready); end
    $display("reset: done");
  endtask

  task automatic test_add();
    req_a = 16'h7FFF; req_b = 16'h0001; req_op = 3'b000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_vec++; if (alu_op !== 3'b000 || alu_a !== 16'h7FFF || alu_b !== 16'h0001) begin n_miss++; $display("FAIL add_exec_drive got a=%h b=%h op=%h want 7fff 0001 0", alu_a, alu_b, alu_op); end
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_miss++; $display("FAIL add_cycle1 got rsp_valid=%h busy=%h want 0 1", rsp_valid, busy); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000_8000) begin n_miss++; $display("FAIL add_result got v=%h r=%h want 1 00008000", rsp_valid, rsp_result); end
    n_vec++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 3'b000) begin n_miss++; $display("FAIL add_resp_alu_idle got a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_miss++; $display("FAIL add_after_hs got v=%h busy=%h rdy=%h want 0 0 1", rsp_valid, busy, req_ready); end
    $display("add 7fff+0001 -> %h", rsp_result);
  endtask

  task automatic test_mul(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    req_a = a; req_b = b; req_op = 3'b111; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_vec++; if (alu_a !== 16'h0 || alu_b !== a) begin n_miss++; $display("FAIL mul_first_iter got a=%h b=%h want 0000 %h", alu_a, alu_b, a); end
    for (int i = 1; i <= 16; i++) begin
      n_vec++; if (alu_op !== 3'b000 || rsp_valid !== 1'b0 || busy !== 1'b1) begin n_miss++; $display("FAIL mul_iter%0d got op=%h v=%h busy=%h want 0 0 1", i, alu_op, rsp_valid, busy); end
      tick();
    end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_result !== exp) begin n_miss++; $display("FAIL mul_%h_%h got v=%h r=%h want 1 %h", a, b, rsp_valid, rsp_result, exp); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_miss++; $display("FAIL mul_after_hs got v=%h busy=%h want 0 0", rsp_valid, busy); end
    $display("mul %h*%h -> %h", a, b, exp);
  endtask

  task automatic test_backpressure();
    req_a = 16'h0005; req_b = 16'h0007; req_op = 3'b001; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000_FFFE || req_ready !== 1'b0) begin n_miss++; $display("FAIL bp_stall%0d got v=%h r=%h rdy=%h want 1 0000fffe 0", k, rsp_valid, rsp_result, req_ready); end
      req_valid = (k == 2);
      req_a = 16'h1111; req_b = 16'h2222; req_op = 3'b000;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_miss++; $display("FAIL bp_no_ghost%0d got v=%h busy=%h want 0 0", k, rsp_valid, busy); end
      tick();
    end
    $display("sub 0005-0007 with stall -> %h", rsp_result);
  endtask

  task automatic test_reset_midop();
    req_a = 16'h1234; req_b = 16'h5678; req_op = 3'b111; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    n_vec++; if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || busy !== 1'b0) begin n_miss++; $display("FAIL midrst_state got v=%h r=%h busy=%h want 0 0 0", rsp_valid, rsp_result, busy); end
    n_vec++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 3'b000) begin n_miss++; $display("FAIL midrst_alu got a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op); end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_miss++; $display("FAIL midrst_no_rsp%0d got v=%h busy=%h want 0 0", i, rsp_valid, busy); end
      tick();
    end
    req_a = 16'h0001; req_b = 16'h0002; req_op = 3'b010; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000_0001) begin n_miss++; $display("FAIL midrst_slt got v=%h r=%h want 1 00000001", rsp_valid, rsp_result); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("reset mid-mul, then slt 0001,0002 -> %h", rsp_result);
  endtask

  task automatic test_sweep();
    logic [31:0] exp;
    int          nrsp;
    int          waited;
    for (int op = 0; op < 7; op++) begin
      for (int rep = 0; rep < 3; rep++) begin
        req_a = 16'($urandom); req_b = 16'($urandom); req_op = 3'(op);
        exp = alu_ref(req_a, req_b, req_op);
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL sweep_ready op%0d got %h want 1", op, req_ready); end
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        nrsp = 0;
        waited = 0;
        while (waited < 40 && !(nrsp == 1 && waited > 8)) begin
          rsp_ready = (waited > 12) ? 1'b1 : 1'($urandom_range(0, 1));
          if (rsp_valid && rsp_ready) begin
            nrsp++;
            n_vec++; if (rsp_result !== exp) begin n_miss++; $display("FAIL sweep_result op%0d a=%h b=%h got %h want %h", op, req_a, req_b, rsp_result, exp); end
          end
          tick();
          waited++;
        end
        rsp_ready = 1'b0;
        n_vec++; if (nrsp !== 1) begin n_miss++; $display("FAIL sweep_count op%0d got %0d responses want 1", op, nrsp); end
        $display("sweep op=%0d a=%h b=%h -> %h", op, req_a, req_b, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    tick();
    test_reset();
    tick();
    test_add();
    test_mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    test_mul(16'h1234, 16'h0003, 32'h0000_369C);
    test_mul(16'h1234, 16'h0000, 32'h0000_0000);
    test_backpressure();
    test_reset_midop();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
